// File: rtl/rc5_key_expand.sv
// rc5_key_expand: iterative RC5-16/16/16 key schedule producing S[0..33] with a combinational read port
module rc5_key_expand #(
  parameter int W         = 16,
  parameter int ROUNDS    = 16,
  parameter int KEY_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic                   busy,
  output logic                   done,
  output logic                   subkeys_valid,
  input  logic [5:0]             sk_idx,
  output logic [W-1:0]           sk_out
);
  localparam int T = 2*ROUNDS+2;
  localparam int C = KEY_BYTES/2;
  localparam int N = 3*((T > C) ? T : C);
  localparam logic [5:0] I_LAST = 6'(T-1);
  localparam logic [2:0] J_LAST = 3'(C-1);
  localparam logic [6:0] K_LAST = 7'(N-1);
  localparam logic [15:0] P16 = 16'hB7E1;
  localparam logic [15:0] Q16 = 16'h9E37;
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_MIX, S_FINISH, S_READY} state_t;
  state_t      r_state;
  logic [15:0] r_s [T];
  logic [15:0] r_l [C];
  logic [15:0] r_a, r_b, r_run;
  logic [5:0]  r_i;
  logic [2:0]  r_j;
  logic [6:0]  r_k;
  logic        r_busy, r_done, r_valid;
  logic        w_accept;
  logic [15:0] w_a, w_ab, w_b;
  function automatic logic [15:0] rotl(input logic [15:0] x, input logic [3:0] n);
    logic [31:0] t;
    t = {x, x} << n;
    return t[31:16];
  endfunction
  assign w_accept = start && (r_state == S_IDLE || r_state == S_READY);
  assign w_a  = rotl(r_s[r_i] + r_a + r_b, 4'd3);
  assign w_ab = w_a + r_b;
  assign w_b  = rotl(r_l[r_j] + w_ab, w_ab[3:0]);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_READY: if (start) begin
          r_state <= S_INIT;
          r_i     <= '0;
          r_busy  <= 1'b1;
          r_valid <= 1'b0;
        end
        S_INIT: begin
          r_i <= (r_i == I_LAST) ? '0 : r_i + 6'd1;
          r_j <= '0;
          r_k <= '0;
          if (r_i == I_LAST) r_state <= S_MIX;
        end
        S_MIX: begin
          r_i <= (r_i == I_LAST) ? '0 : r_i + 6'd1;
          r_j <= (r_j == J_LAST) ? '0 : r_j + 3'd1;
          r_k <= r_k + 7'd1;
          if (r_k == K_LAST) begin
            r_state <= S_FINISH;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_FINISH: begin
          r_state <= S_READY;
          r_done  <= 1'b0;
          r_valid <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  // Table, key words and accumulators are never cleared; reads are gated by r_valid
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int n = 0; n < C; n++) r_l[n] <= key[16*n +: 16];
      r_run <= P16;
    end else if (r_state == S_INIT) begin
      r_s[r_i] <= r_run;
      r_run    <= r_run + Q16;
      r_a      <= '0;
      r_b      <= '0;
    end else if (r_state == S_MIX) begin
      r_s[r_i] <= w_a;
      r_a      <= w_a;
      r_l[r_j] <= w_b;
      r_b      <= w_b;
    end
  end
  assign busy          = r_busy;
  assign done          = r_done;
  assign subkeys_valid = r_valid;
  assign sk_out        = (r_valid && sk_idx <= I_LAST) ? r_s[sk_idx] : '0;
endmodule
